// File: rtl/perf_pkg.sv
// Shared constants and record type for the per-stage cycle capture path.
package perf_pkg;

  localparam int CNT_W = 32;

  localparam logic SRC_STAGE1 = 1'b0;
  localparam logic SRC_STAGE2 = 1'b1;

  // One captured record: which stage fired and the counter value at that edge.
  typedef struct packed {
    logic             src;
    logic [CNT_W-1:0] count;
  } perf_rec_t;

endpackage

// File: rtl/perf_fifo.sv
// Synchronous FIFO with two ordered write ports and one read port.
// Port 0 is always written ahead of port 1. Writes beyond the free-slot
// count are dropped; the number dropped each cycle is reported on drop_n.
// A pop in the same cycle frees its slot for that cycle's writes.
module perf_fifo #(
  parameter  int W     = 33,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          wr0_en,
  input  logic [W-1:0]  wr0_data,
  input  logic          wr1_en,
  input  logic [W-1:0]  wr1_data,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic [1:0]    drop_n
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop;
  logic [LW-1:0] free;
  logic [1:0]    n_req;
  logic [1:0]    n_acc;
  logic [W-1:0]  first_data;
  logic [W-1:0]  second_data;

  assign rd_valid = (level != '0);
  assign rd_data  = mem[rptr];

  // Compact requested writes into order and limit them to the free slots.
  always_comb begin
    pop         = rd_en & rd_valid;
    free        = LW'(DEPTH) - level + LW'(pop);
    n_req       = {1'b0, wr0_en} + {1'b0, wr1_en};
    first_data  = wr0_en ? wr0_data : wr1_data;
    second_data = wr1_data;
    if (free >= LW'(n_req)) n_acc = n_req;
    else                    n_acc = free[1:0];
    drop_n = n_req - n_acc;
  end

  // Storage, pointers and occupancy; clear empties the FIFO outright.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (n_acc >= 2'd1) mem[wptr] <= first_data;
      if (n_acc == 2'd2) mem[wptr + AW'(1)] <= second_data;
      wptr  <= wptr + AW'(n_acc);
      rptr  <= rptr + AW'(pop);
      level <= level + LW'(n_acc) - LW'(pop);
    end
  end

endmodule

// File: rtl/perf_capture.sv
// Latches stage cycle counters on the rising edge of their stop markers and
// queues them for the host readout.
// Optional feature macro: PERF_CAPTURE_DROPCNT_EN enables the saturating
// dropped-record counter; otherwise drop_count is tied to zero.
// Output handshake: a record transfers in any cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready low,
// out_src/out_count hold the FIFO head unchanged.
module perf_capture
  import perf_pkg::*;
#(
  parameter int CNT_W = perf_pkg::CNT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic [CNT_W-1:0]         counter1,
  input  logic [CNT_W-1:0]         counter2,
  input  logic                     stop1,
  input  logic                     stop2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_src,
  output logic [CNT_W-1:0]         out_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  logic             stop1_q;
  logic             stop2_q;
  logic             rise1;
  logic             rise2;
  logic [1:0]       n_drop;
  logic [CNT_W:0]   head;

  assign rise1 = stop1 & ~stop1_q;
  assign rise2 = stop2 & ~stop2_q;

  // Edge registers reset high so a marker already asserted at release is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stop1_q <= 1'b1;
      stop2_q <= 1'b1;
    end else begin
      stop1_q <= stop1;
      stop2_q <= stop2;
    end
  end

  perf_fifo #(
    .W     (CNT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (clear),
    .wr0_en   (rise1 & ~clear),
    .wr0_data ({SRC_STAGE1, counter1}),
    .wr1_en   (rise2 & ~clear),
    .wr1_data ({SRC_STAGE2, counter2}),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (head),
    .level    (level),
    .drop_n   (n_drop)
  );

  assign out_src   = head[CNT_W];
  assign out_count = head[CNT_W-1:0];

  // Sticky flag for any dropped capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            overflow <= 1'b0;
    else if (clear)         overflow <= 1'b0;
    else if (n_drop != '0)  overflow <= 1'b1;
  end

`ifdef PERF_CAPTURE_DROPCNT_EN
  logic [8:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + {7'd0, n_drop};

  // Saturating count of dropped records.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          drop_count <= 8'd0;
    else if (clear)       drop_count <= 8'd0;
    else if (drop_sum[8]) drop_count <= 8'd255;
    else                  drop_count <= drop_sum[7:0];
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_perf_capture.sv
// Directed bench for perf_capture with hand-computed expectations.
module tb_perf_capture;
  import perf_pkg::*;

  localparam int DEPTH = 4;

  logic              clk;
  logic              resetn;
  logic              clear;
  logic [CNT_W-1:0]  counter1;
  logic [CNT_W-1:0]  counter2;
  logic              stop1;
  logic              stop2;
  logic              out_valid;
  logic              out_ready;
  logic              out_src;
  logic [CNT_W-1:0]  out_count;
  logic [2:0]        level;
  logic              overflow;
  logic [7:0]        drop_count;

  int errors = 0;
  int checks = 0;
  perf_rec_t head;

`ifdef PERF_CAPTURE_DROPCNT_EN
  localparam logic [7:0] EXP_DROP1 = 8'd1;
`else
  localparam logic [7:0] EXP_DROP1 = 8'd0;
`endif

  perf_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .counter1   (counter1),
    .counter2   (counter2),
    .stop1      (stop1),
    .stop2      (stop2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src    (out_src),
    .out_count  (out_count),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stop1 pulse: high for a cycle, low for a cycle.
  task automatic pulse1(input logic [CNT_W-1:0] c);
    counter1 = c;
    stop1 = 1'b1;
    tick();
    stop1 = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; clear = 1'b0; counter1 = '0; counter2 = '0;
    stop1 = 1'b0; stop2 = 1'b0; out_ready = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_src, out_count, level, overflow, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b s=%0b c=%0d l=%0d o=%0b d=%0d required all zero",
               out_valid, out_src, out_count, level, overflow, drop_count);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1; counter1 = 32'd1000; stop1 = 1'b1;
    tick();
    stop1 = 1'b0;
    head = {out_src, out_count};
    checks++;
    if (out_valid !== 1'b1 || head !== {SRC_STAGE1, 32'd1000}) begin
      errors++;
      $display("FAIL single_capture: got v=%0b src=%0b cnt=%0d required v=1 src=0 cnt=1000",
               out_valid, out_src, out_count);
    end
    tick();
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got level=%0d v=%0b required level=0 v=0", level, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; counter1 = 32'd50; counter2 = 32'd7;
    stop1 = 1'b1; stop2 = 1'b1;
    tick();
    stop1 = 1'b0; stop2 = 1'b0;
    checks++;
    if (level !== 3'd2 || out_src !== 1'b0 || out_count !== 32'd50) begin
      errors++;
      $display("FAIL simul_first: got level=%0d src=%0b cnt=%0d required level=2 src=0 cnt=50",
               level, out_src, out_count);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (level !== 3'd1 || out_src !== 1'b1 || out_count !== 32'd7) begin
      errors++;
      $display("FAIL simul_second: got level=%0d src=%0b cnt=%0d required level=1 src=1 cnt=7",
               level, out_src, out_count);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL simul_empty: got level=%0d required 0", level);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse1(32'(100 + i));
      checks++;
      if (out_src !== 1'b0 || out_count !== 32'd100) begin
        errors++;
        $display("FAIL ovf_head_stable[%0d]: got src=%0b cnt=%0d required src=0 cnt=100",
                 i, out_src, out_count);
      end
    end
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1 || drop_count !== EXP_DROP1) begin
      errors++;
      $display("FAIL ovf_state: got level=%0d ovf=%0b drop=%0d required level=4 ovf=1 drop=%0d",
               level, overflow, drop_count, EXP_DROP1);
    end
  endtask

  task automatic test_full_pop();
    do_clear();
    checks++;
    if (level !== 3'd0 || overflow !== 1'b0 || drop_count !== 8'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush: got level=%0d ovf=%0b drop=%0d v=%0b required 0 0 0 0",
               level, overflow, drop_count, out_valid);
    end
    for (int i = 0; i < 4; i++) pulse1(32'(200 + i));
    out_ready = 1'b1; counter1 = 32'd300; stop1 = 1'b1;
    tick();
    stop1 = 1'b0; out_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || out_count !== 32'd201) begin
      errors++;
      $display("FAIL full_pop_push: got level=%0d ovf=%0b head=%0d required level=4 ovf=0 head=201",
               level, overflow, out_count);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [CNT_W-1:0] exp_c;
      exp_c = (i == 3) ? 32'd300 : 32'(201 + i);
      checks++;
      if (out_valid !== 1'b1 || out_count !== exp_c) begin
        errors++;
        $display("FAIL full_drain[%0d]: got v=%0b cnt=%0d required v=1 cnt=%0d",
                 i, out_valid, out_count, exp_c);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL full_drain_empty: got level=%0d required 0", level);
    end
  endtask

  task automatic test_clear_vs_capture();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pulse1(32'(400 + i));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: got level=%0d ovf=%0b required level=3 ovf=1", level, overflow);
    end
    counter2 = 32'd999; stop2 = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_priority: got level=%0d v=%0b ovf=%0b drop=%0d required 0 0 0 0",
               level, out_valid, overflow, drop_count);
    end
    tick();
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL clear_no_late_capture: got level=%0d required 0", level);
    end
    stop2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_high();
    out_ready = 1'b0;
    pulse1(32'd55);
    resetn = 1'b0;
    #1;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || out_count !== '0) begin
      errors++;
      $display("FAIL async_reset: got level=%0d v=%0b cnt=%0d required 0 0 0",
               level, out_valid, out_count);
    end
    stop1 = 1'b1; counter1 = 32'd66;
    tick();
    resetn = 1'b1;
    tick(); tick();
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL high_at_release: got level=%0d required 0", level);
    end
    stop1 = 1'b0;
    tick();
    counter1 = 32'd77; stop1 = 1'b1;
    tick();
    stop1 = 1'b0;
    tick();
    checks++;
    if (level !== 3'd1 || out_count !== 32'd77 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL rise_after_release: got level=%0d src=%0b cnt=%0d required level=1 src=0 cnt=77",
               level, out_src, out_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_clear_vs_capture();
    test_reset_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
